host_monitor: RTL and testbench
===============================

# host_monitor

Synthesizable host-interface monitor that snoops the core's data-memory bus and detects stores to up to `CHANNELS` programmable host addresses. Each channel is either a terminate channel (latches an exit code and raises `done`) or a console channel (queues the low byte into a character FIFO for a UART/print sink). A cycle watchdog forces termination when a program runs past a programmable limit. It sits beside the core in the SoC and replaces per-bench tohost detection with one reusable block usable in simulation and on FPGA.

## Interface
- `CHANNELS`, 2: number of host address channels (1..8).
- `FIFO_DEPTH`, 8: console FIFO entries; power of two, at least 2.
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_valid`  in  1  bus request valid (snooped, never driven).
- `mem_addr`  in  32  bus byte address.
- `mem_wdata`  in  32  bus write data.
- `mem_wstrb`  in  4  byte strobes; all-zero means a read.
- `mem_ready`  in  1  bus handshake complete.
- `host_base`  in  32*CHANNELS  word address of channel i at bits [32i+31:32i]; bits [1:0] ignored.
- `host_mode`  in  CHANNELS  per channel: 0 = terminate, 1 = console.
- `timeout`  in  32  watchdog limit in cycles; 0 disables the watchdog.
- `done`  out  1  sticky termination flag.
- `result`  out  32  exit code; 32'hFFFF_FFFF on timeout.
- `timed_out`  out  1  sticky; termination was caused by the watchdog.
- `cycle_count`  out  32  cycles spent in RUN.
- `chr_valid`  out  1  console FIFO is not empty.
- `chr_data`  out  8  FIFO head byte.
- `chr_ready`  in  1  consumer pops the head when `chr_valid` is also high.
- `overflow`  out  1  sticky; a console byte was dropped.

## Operation
- Hit on channel i: `mem_valid & mem_ready & |mem_wstrb & (mem_addr[31:2] == host_base_i[31:2])`.
- At most one hit per cycle. If several channels match, the lowest index wins.
- State machine has two states, RUN and DONE. Reset enters RUN.
- RUN + terminate hit: `result <= mem_wdata`, `done <= 1`, go to DONE.
- DONE: terminate hits are ignored and `result` is frozen. Console channels stay fully functional.
- Console hit with `mem_wstrb[0]=1`: push `mem_wdata[7:0]`. With `mem_wstrb[0]=0` the hit is ignored.
- Push while full without a same-cycle pop: the byte is dropped and `overflow <= 1`.
- Push while full with a same-cycle pop: the push is accepted and occupancy stays FIFO_DEPTH.
- Pop while empty has no effect. Push and pop in the same cycle leave the count unchanged.
- Watchdog, evaluated only in RUN:
  - `cycle_count` increments every RUN cycle and saturates at 32'hFFFF_FFFF.
  - When `timeout != 0` and `cycle_count == timeout - 1`, the next edge sets `timed_out=1`, `done=1`, `result=32'hFFFF_FFFF` and moves to DONE.
  - A terminate hit in that same cycle takes priority: `result` = wdata and `timed_out` stays 0.
- `cycle_count` holds its value in DONE.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. The count has one extra bit.

## Timing
- Reset values: `done=0`, `result=0`, `timed_out=0`, `cycle_count=0`, `chr_valid=0`, `chr_data=0`, `overflow=0`. State is RUN and the FIFO is empty.
- Reset asserted mid-operation clears everything immediately and asynchronously, including queued bytes.
- Hit at edge N:
  - `done` and `result` are valid after edge N (visible in cycle N+1).
  - A pushed byte makes `chr_valid` high after edge N.
- `chr_data` is show-ahead: the head byte is stable while `chr_valid=1 & chr_ready=0`.
- Sustained throughput is one push and one pop per cycle.
- With `timeout=T`, `done` rises after the T-th rising edge following reset deassertion.

## Structure
- Add to package `configure`:
  - typedef `host_state_t` {RUN, DONE}
  - constants `HOST_MODE_TERM=0`, `HOST_MODE_CONS=1`, `HOST_TIMEOUT_CODE=32'hFFFF_FFFF`.
- Sub-module `host_fifo`, parametrised by width (8) and depth: async active-low reset, push/pop, full/empty, show-ahead output.
- Top level holds the channel match/priority logic, the state machine, the watchdog and the sticky flags.

## Test plan
- Channel 0 terminate at 0x8000_1000; store 0x0000_0001 with wstrb 4'b1111 → `done=1`, `result=1` next cycle; a second store of 0x5 leaves `result=1`.
- Channel 1 console; stores 'H','i' in back-to-back cycles with `chr_ready=0` → `chr_valid=1`, `chr_data=0x48`; raise `chr_ready` → 0x48 then 0x69 on consecutive cycles, then `chr_valid=0`.
- FIFO_DEPTH=8, `chr_ready=0`: 9 console stores → 9th byte dropped, `overflow=1`; with the FIFO full, a 10th store with `chr_ready=1` → that byte is accepted.
- `timeout=20`, no hits → `done=1`, `timed_out=1`, `result=32'hFFFF_FFFF`, `cycle_count=20`, frozen afterwards.
- Both channels at the same address, modes term/console; store 0x2A → channel 0 wins: `result=0x2A`, FIFO stays empty.
- Reset pulsed low while 3 bytes are queued and `done=1` → all outputs return to their reset values immediately; a terminate store of 0x3 afterwards → `result=3`.

Source files
------------

// File: rtl/configure.sv
// Shared types and constants for the host-interface monitor.
package configure;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CHR_W  = 8;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } host_state_t;

    localparam logic              HOST_MODE_TERM    = 1'b0;
    localparam logic              HOST_MODE_CONS    = 1'b1;
    localparam logic [DATA_W-1:0] HOST_TIMEOUT_CODE = 32'hFFFF_FFFF;

endpackage

// File: rtl/host_fifo.sv
// Show-ahead FIFO for console bytes; a push into a full FIFO is accepted only with a same-cycle pop.
module host_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata_c,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign empty_c = (count_q == '0);
    assign do_pop  = pop & ~empty_c;
    assign do_push = push & (~full_c | do_pop);
    assign rdata_c = empty_c ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/host_monitor.sv
// Snoops data-memory stores to programmable host addresses: terminate channels latch an exit code,
// console channels queue bytes, and a cycle watchdog forces termination.
module host_monitor
    import configure::*;
#(
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       mem_valid,
    input  logic [DATA_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_wdata,
    input  logic [3:0]                 mem_wstrb,
    input  logic                       mem_ready,
    input  logic [DATA_W*CHANNELS-1:0] host_base,
    input  logic [CHANNELS-1:0]        host_mode,
    input  logic [DATA_W-1:0]          timeout,
    output logic                       done,
    output logic [DATA_W-1:0]          result,
    output logic                       timed_out,
    output logic [DATA_W-1:0]          cycle_count,
    output logic                       chr_valid,
    output logic [CHR_W-1:0]           chr_data,
    input  logic                       chr_ready,
    output logic                       overflow
);

    host_state_t       state_q, state_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              timed_out_q, timed_out_d;
    logic [DATA_W-1:0] cycle_count_q, cycle_count_d;
    logic              overflow_q, overflow_d;

    logic bus_wr;
    logic hit_any;
    logic hit_mode;
    logic term_hit;
    logic cons_push;
    logic wd_expire;
    logic fifo_full;
    logic fifo_empty;
    logic unused_lsb;

    assign bus_wr = mem_valid & mem_ready & (|mem_wstrb);

    // Scan from the top so the lowest matching channel is the one that sticks.
    always_comb begin
        hit_any  = 1'b0;
        hit_mode = HOST_MODE_TERM;
        for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
            if (bus_wr && (mem_addr[31:2] == host_base[32*i+2 +: 30])) begin
                hit_any  = 1'b1;
                hit_mode = host_mode[i];
            end
        end
    end

    // Byte-offset bits of the addresses do not take part in the match.
    always_comb begin
        unused_lsb = ^mem_addr[1:0];
        for (int i = 0; i < int'(CHANNELS); i++) begin
            unused_lsb = unused_lsb ^ (^host_base[32*i +: 2]);
        end
    end

    assign term_hit  = hit_any & (hit_mode == HOST_MODE_TERM);
    assign cons_push = hit_any & (hit_mode == HOST_MODE_CONS) & mem_wstrb[0];
    assign wd_expire = (timeout != '0) && (cycle_count_q == timeout - 32'd1);

    always_comb begin
        state_d       = state_q;
        done_d        = done_q;
        result_d      = result_q;
        timed_out_d   = timed_out_q;
        cycle_count_d = cycle_count_q;
        overflow_d    = overflow_q | (cons_push & fifo_full & ~chr_ready);
        case (state_q)
            RUN: begin
                if (cycle_count_q != '1) begin
                    cycle_count_d = cycle_count_q + 32'd1;
                end
                if (term_hit) begin
                    result_d = mem_wdata;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else if (wd_expire) begin
                    result_d    = HOST_TIMEOUT_CODE;
                    timed_out_d = 1'b1;
                    done_d      = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            done_q        <= 1'b0;
            result_q      <= '0;
            timed_out_q   <= 1'b0;
            cycle_count_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            done_q        <= done_d;
            result_q      <= result_d;
            timed_out_q   <= timed_out_d;
            cycle_count_q <= cycle_count_d;
            overflow_q    <= overflow_d;
        end
    end

    host_fifo #(
        .WIDTH(CHR_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clock),
        .rst_n  (reset),
        .push   (cons_push),
        .wdata  (mem_wdata[CHR_W-1:0]),
        .pop    (chr_ready),
        .rdata_c(chr_data),
        .full_c (fifo_full),
        .empty_c(fifo_empty)
    );

    assign done        = done_q;
    assign result      = result_q;
    assign timed_out   = timed_out_q;
    assign cycle_count = cycle_count_q;
    assign overflow    = overflow_q;
    assign chr_valid   = ~fifo_empty;

endmodule

// File: tb/tb_host_monitor.sv
// Bench for host_monitor: directed vector table, hand-written corner sequences, and randomized
// traffic against a queue-based behavioural model.
module tb_host_monitor;

    localparam int unsigned CH    = 2;
    localparam int unsigned DEPTH = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            mem_valid = 1'b0;
    logic [31:0]     mem_addr = '0;
    logic [31:0]     mem_wdata = '0;
    logic [3:0]      mem_wstrb = '0;
    logic            mem_ready = 1'b0;
    logic [32*CH-1:0] host_base = '0;
    logic [CH-1:0]   host_mode = '0;
    logic [31:0]     timeout = '0;
    logic            chr_ready = 1'b0;
    logic            done;
    logic [31:0]     result;
    logic            timed_out;
    logic [31:0]     cycle_count;
    logic            chr_valid;
    logic [7:0]      chr_data;
    logic            overflow;

    always #5 clock = ~clock;

    host_monitor #(.CHANNELS(CH), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .host_base(host_base), .host_mode(host_mode), .timeout(timeout),
        .done(done), .result(result), .timed_out(timed_out), .cycle_count(cycle_count),
        .chr_valid(chr_valid), .chr_data(chr_data), .chr_ready(chr_ready),
        .overflow(overflow)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model state
    bit          m_done, m_to, m_ovf;
    logic [31:0] m_res, m_cnt;
    byte unsigned m_q[$];

    typedef struct {
        logic        v;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        crdy;
        logic        e_done;
        logic [31:0] e_result;
        logic        e_cv;
        logic [7:0]  e_cd;
    } vec_t;

    vec_t vt[10];
    byte unsigned drain_exp[8] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h39};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        m_done = 0; m_to = 0; m_ovf = 0; m_res = '0; m_cnt = '0;
        m_q.delete();
    endtask

    // One clock edge of the host monitor, evaluated from the current inputs.
    task automatic model_step();
        int ch = -1;
        int sz;
        bit pop, push, wd;
        if (mem_valid && mem_ready && mem_wstrb != 4'b0)
            for (int i = 0; i < CH; i++)
                if (ch < 0 && mem_addr[31:2] == host_base[32*i+2 +: 30]) ch = i;
        sz   = m_q.size();
        pop  = chr_ready && sz > 0;
        push = ch >= 0 && host_mode[ch] && mem_wstrb[0];
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (sz < DEPTH || pop) m_q.push_back(mem_wdata[7:0]);
            else m_ovf = 1;
        end
        if (!m_done) begin
            wd = timeout != 0 && m_cnt == timeout - 1;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (ch >= 0 && !host_mode[ch]) begin
                m_res = mem_wdata; m_done = 1;
            end else if (wd) begin
                m_res = 32'hFFFF_FFFF; m_done = 1; m_to = 1;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic set_idle();
        mem_valid = 0; mem_ready = 0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        mem_valid = 1; mem_ready = 1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 0;
        set_idle();
        chr_ready = 0;
        model_reset();
        #2 reset = 1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_timed_out"}, 32'(timed_out), 0);
        check({tag, "_cycle_count"}, cycle_count, 0);
        check({tag, "_chr_valid"}, 32'(chr_valid), 0);
        check({tag, "_chr_data"}, 32'(chr_data), 0);
        check({tag, "_overflow"}, 32'(overflow), 0);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_done"}, 32'(done), 32'(m_done));
        check({tag, "_result"}, result, m_res);
        check({tag, "_timed_out"}, 32'(timed_out), 32'(m_to));
        check({tag, "_cycle_count"}, cycle_count, m_cnt);
        check({tag, "_chr_valid"}, 32'(chr_valid), 32'(m_q.size() != 0));
        check({tag, "_chr_data"}, 32'(chr_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    initial begin
        int n;
        //        v  addr           wdata         wstrb    crdy done result cv cd
        vt[0] = '{1'b0, 32'h8000_1000, 32'h7,  4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00};
        vt[0].v = 1'b1;  // a read: strobes all zero
        vt[1] = '{1'b1, 32'h8000_1000, 32'h1,  4'b1111, 1'b0, 1'b1, 32'h1, 1'b0, 8'h00};
        vt[2] = '{1'b1, 32'h8000_1000, 32'h5,  4'b1111, 1'b0, 1'b1, 32'h1, 1'b0, 8'h00};
        vt[3] = '{1'b1, 32'h8000_2000, 32'h48, 4'b1111, 1'b0, 1'b1, 32'h1, 1'b1, 8'h48};
        vt[4] = '{1'b1, 32'h8000_2000, 32'h69, 4'b1111, 1'b0, 1'b1, 32'h1, 1'b1, 8'h48};
        vt[5] = '{1'b1, 32'h8000_2000, 32'h21, 4'b0010, 1'b0, 1'b1, 32'h1, 1'b1, 8'h48};
        vt[6] = '{1'b0, 32'h0,         32'h0,  4'b0000, 1'b1, 1'b1, 32'h1, 1'b1, 8'h69};
        vt[7] = '{1'b0, 32'h0,         32'h0,  4'b0000, 1'b1, 1'b1, 32'h1, 1'b0, 8'h00};
        vt[8] = '{1'b1, 32'h8000_2003, 32'h5A, 4'b0001, 1'b1, 1'b1, 32'h1, 1'b1, 8'h5A};
        vt[9] = '{1'b0, 32'h0,         32'h0,  4'b0000, 1'b1, 1'b1, 32'h1, 1'b0, 8'h00};

        // Directed vector table
        host_base = {32'h8000_2000, 32'h8000_1000};
        host_mode = 2'b10;
        timeout   = 0;
        apply_reset();
        check_zero("reset");
        for (int k = 0; k < 10; k++) begin
            mem_valid = vt[k].v; mem_ready = vt[k].v; mem_addr = vt[k].addr;
            mem_wdata = vt[k].wdata; mem_wstrb = vt[k].wstrb; chr_ready = vt[k].crdy;
            tick();
            check($sformatf("vec%0d_done", k), 32'(done), 32'(vt[k].e_done));
            check($sformatf("vec%0d_result", k), result, vt[k].e_result);
            check($sformatf("vec%0d_chr_valid", k), 32'(chr_valid), 32'(vt[k].e_cv));
            check($sformatf("vec%0d_chr_data", k), 32'(chr_data), 32'(vt[k].e_cd));
        end

        // Overflow: nine stores into an 8-deep FIFO, then a push with a same-cycle pop
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            store(32'h8000_2000, 32'h30 + 32'(k), 4'b1111);
            tick();
            check($sformatf("ovf_store%0d", k), 32'(overflow), (k == 8) ? 32'd1 : 32'd0);
        end
        check("ovf_head", 32'(chr_data), 32'h30);
        store(32'h8000_2000, 32'h39, 4'b1111);
        chr_ready = 1;
        tick();
        check("ovf_full_pop_head", 32'(chr_data), 32'h31);
        check("ovf_sticky", 32'(overflow), 1);
        set_idle();
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 8) check($sformatf("drain%0d", k), 32'(chr_data), 32'(drain_exp[k]));
            else check("drain_empty", 32'(chr_valid), 0);
        end

        // Watchdog
        timeout = 20;
        apply_reset();
        n = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (done) begin
                n = k;
                break;
            end
        end
        check("wd_edge", 32'(n), 20);
        check("wd_timed_out", 32'(timed_out), 1);
        check("wd_result", result, 32'hFFFF_FFFF);
        check("wd_cycle_count", cycle_count, 20);
        for (int k = 0; k < 5; k++) tick();
        check("wd_frozen_count", cycle_count, 20);
        check("wd_frozen_result", result, 32'hFFFF_FFFF);

        // Two channels on one address: channel 0 wins
        timeout   = 0;
        host_base = {32'h8000_3000, 32'h8000_3000};
        apply_reset();
        store(32'h8000_3000, 32'h2A, 4'b1111);
        tick();
        set_idle();
        check("prio_result", result, 32'h2A);
        check("prio_fifo_empty", 32'(chr_valid), 0);

        // Asynchronous reset with bytes queued and done set
        host_base = {32'h8000_2000, 32'h8000_1000};
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            store(32'h8000_2000, 32'h61 + 32'(k), 4'b1111);
            tick();
        end
        store(32'h8000_1000, 32'h77, 4'b1111);
        tick();
        set_idle();
        check("pre_rst_done", 32'(done), 1);
        check("pre_rst_valid", 32'(chr_valid), 1);
        reset = 0;
        #1;
        check_zero("async_rst");
        model_reset();
        #1 reset = 1;
        store(32'h8000_1000, 32'h3, 4'b1111);
        tick();
        set_idle();
        check("post_rst_result", result, 3);
        check("post_rst_done", 32'(done), 1);

        // Randomized traffic against the model
        for (int ep = 0; ep < 6; ep++) begin
            logic [31:0] b0, b1;
            int sel;
            b0 = $urandom();
            b1 = ($urandom_range(0, 3) == 0) ? b0 : $urandom();
            host_base = {b1, b0};
            host_mode = 2'($urandom());
            timeout   = $urandom_range(0, 40);
            apply_reset();
            for (int c = 0; c < 80; c++) begin
                sel = $urandom_range(0, 3);
                mem_addr  = (sel == 0) ? (b0 ^ 32'($urandom_range(0, 3))) :
                            (sel == 1) ? (b1 ^ 32'($urandom_range(0, 3))) : $urandom();
                mem_valid = $urandom_range(0, 3) != 0;
                mem_ready = $urandom_range(0, 3) != 0;
                mem_wstrb = 4'($urandom());
                mem_wdata = $urandom();
                chr_ready = $urandom_range(0, 2) == 0;
                tick();
                check_model($sformatf("rand%0d_%0d", ep, c));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
